cvxif_copro_responder: RTL and testbench

- Coprocessor-side responder for the CoreV-X-Interface.
- Accepts issue requests from the core-side X-interface FU.
- Decodes a small custom-3 instruction set, executes single- or multi-cycle, and returns results in order through a result buffer using the x_result valid/ready handshake.
- Serves as the team's reference coprocessor for core integration and verification.

---
 rtl/copro_pkg.sv | 25 ++
 rtl/cvxif_pkg.sv | 55 +++++
 rtl/copro_result_fifo.sv | 70 +++++++
 rtl/cvxif_copro_responder.sv | 185 ++++++++++++++++++
 tb/tb_cvxif_copro_responder.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/copro_pkg.sv
// Shared constants and types for the custom-3 coprocessor responder.
package copro_pkg;

   localparam logic [6:0] OPCODE_CUSTOM3 = 7'h7B;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_MUL = 3'd1,
      OP_NOP = 3'd2,
      OP_EXC = 3'd3
   } copro_op_e;

   typedef struct packed {
      logic [cvxif_pkg::X_ID_WIDTH-1:0] id;
      logic [cvxif_pkg::XLEN-1:0]       data;
      logic                             we;
      logic                             exc;
      logic [5:0]                       exccode;
   } copro_result_t;

   // Responder FSM state values
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/cvxif_pkg.sv
// CoreV-X-Interface request/response types as seen by a coprocessor.
// Sized for a 32-bit core with two source registers and 4-bit instruction ids.
package cvxif_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned X_NUM_RS   = 2;
   localparam int unsigned X_ID_WIDTH = 4;

   typedef struct packed {
      logic [31:0]                      instr;
      logic [1:0]                       mode;
      logic [X_ID_WIDTH-1:0]            id;
      logic [X_NUM_RS-1:0][XLEN-1:0]    rs;
      logic [X_NUM_RS-1:0]              rs_valid;
   } x_issue_req_t;

   typedef struct packed {
      logic accept;
      logic writeback;
      logic dualwrite;
      logic dualread;
      logic loadstore;
      logic exc;
   } x_issue_resp_t;

   typedef struct packed {
      logic [X_ID_WIDTH-1:0] id;
      logic                  x_commit_kill;
   } x_commit_t;

   typedef struct packed {
      logic [X_ID_WIDTH-1:0] id;
      logic [XLEN-1:0]       data;
      logic [4:0]            rd;
      logic                  we;
      logic                  exc;
      logic [5:0]            exccode;
   } x_result_t;

   typedef struct packed {
      logic          x_issue_valid;
      x_issue_req_t  x_issue_req;
      logic          x_commit_valid;
      x_commit_t     x_commit;
      logic          x_result_ready;
   } cvxif_req_t;

   typedef struct packed {
      logic          x_issue_ready;
      x_issue_resp_t x_issue_resp;
      logic          x_result_valid;
      x_result_t     x_result;
   } cvxif_resp_t;

endpackage

// File: rtl/copro_result_fifo.sv
// In-order result buffer; DEPTH must be a power of two so the pointers wrap
// for free.
module copro_result_fifo
   import copro_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      push_i,
   input  copro_result_t             data_i,
   input  logic                      pop_i,
   output copro_result_t             data_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [$clog2(DEPTH):0]    count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   copro_result_t mem_q [DEPTH];
   copro_result_t mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: decodes custom-3 ADD/MUL/NOP/EXC and returns
// results in order. Define COPRO_MUL_EN to build the multi-cycle multiplier.
//
//   state   | meaning
//   IDLE    | accepting issues while the result buffer has room
//   BUSY    | multiply in flight; issue stalled until product is buffered or killed
module cvxif_copro_responder
   import cvxif_pkg::*;
   import copro_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned MUL_LATENCY = 3
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  cvxif_req_t  cvxif_req_i,
   output cvxif_resp_t cvxif_resp_o,
   output logic        busy_o
);

   x_issue_req_t            ireq;
   logic                    fmt_ok, rs_ok;
   logic                    dec_legal, dec_we, dec_exc, dec_mul;
   logic [XLEN-1:0]         dec_data;
   logic [5:0]              dec_exccode;
   logic                    accept, issue_ready, issue_fire, issue_push;
   logic                    fsm_busy, mul_push;
   copro_result_t           issue_entry, mul_entry, fifo_in, fifo_head;
   logic                    fifo_full, fifo_empty, fifo_pop;
   logic [$clog2(DEPTH):0]  fifo_count;

   assign ireq   = cvxif_req_i.x_issue_req;
   assign fmt_ok = (ireq.instr[6:0] == OPCODE_CUSTOM3) && (ireq.instr[31:25] == 7'd0);
   assign rs_ok  = &ireq.rs_valid;

   always_comb begin
      dec_legal   = 1'b0;
      dec_we      = 1'b0;
      dec_exc     = 1'b0;
      dec_mul     = 1'b0;
      dec_data    = '0;
      dec_exccode = '0;
      if (fmt_ok) begin
         case (ireq.instr[14:12])
            OP_ADD: if (rs_ok) begin
               dec_legal = 1'b1;
               dec_we    = 1'b1;
               dec_data  = ireq.rs[0] + ireq.rs[1];
            end
`ifdef COPRO_MUL_EN
            OP_MUL: if (rs_ok) begin
               dec_legal = 1'b1;
               dec_we    = 1'b1;
               dec_mul   = 1'b1;
            end
`endif
            OP_NOP: dec_legal = 1'b1;
            OP_EXC: begin
               dec_legal   = 1'b1;
               dec_exc     = 1'b1;
               dec_exccode = ireq.rs[1][5:0];
            end
            default: dec_legal = 1'b0;
         endcase
      end
   end

   assign accept      = cvxif_req_i.x_issue_valid && dec_legal;
   assign issue_ready = !fsm_busy && !fifo_full;
   assign issue_fire  = cvxif_req_i.x_issue_valid && issue_ready;
   // Multiplies enqueue from the FSM at completion, not at the accepting edge
   assign issue_push  = issue_fire && dec_legal && !dec_mul;

   assign issue_entry = '{id: ireq.id, data: dec_data, we: dec_we,
                          exc: dec_exc, exccode: dec_exccode};

`ifdef COPRO_MUL_EN
   localparam int unsigned CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

   logic [0:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [X_ID_WIDTH-1:0] mul_id_q, mul_id_d;
   logic [XLEN-1:0]       op_a_q, op_a_d, op_b_q, op_b_d;
   logic [XLEN-1:0]       product;
   logic                  kill;

   assign product = op_a_q * op_b_q;
   assign kill    = cvxif_req_i.x_commit_valid && cvxif_req_i.x_commit.x_commit_kill &&
                    (cvxif_req_i.x_commit.id == mul_id_q);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mul_id_d = mul_id_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      mul_push = 1'b0;
      case (state_q)
         ST_IDLE: if (issue_fire && dec_mul) begin
            state_d  = ST_BUSY;
            cnt_d    = CW'(MUL_LATENCY - 1);
            mul_id_d = ireq.id;
            op_a_d   = ireq.rs[0];
            op_b_d   = ireq.rs[1];
         end
         ST_BUSY: begin
            if (kill) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               // Counter parks at zero while the buffer is full
               if (!fifo_full) begin
                  mul_push = 1'b1;
                  state_d  = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         mul_id_q <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mul_id_q <= mul_id_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
      end
   end

   assign fsm_busy  = (state_q == ST_BUSY);
   assign mul_entry = '{id: mul_id_q, data: product, we: 1'b1, exc: 1'b0, exccode: 6'd0};
`else
   assign fsm_busy  = 1'b0;
   assign mul_push  = 1'b0;
   assign mul_entry = '0;
`endif

   assign fifo_in  = mul_push ? mul_entry : issue_entry;
   assign fifo_pop = !fifo_empty && cvxif_req_i.x_result_ready;

   copro_result_fifo #(
      .DEPTH (DEPTH)
   ) u_result_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (issue_push || mul_push),
      .data_i  (fifo_in),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      cvxif_resp_o                        = '0;
      cvxif_resp_o.x_issue_ready          = issue_ready;
      cvxif_resp_o.x_issue_resp.accept    = accept;
      cvxif_resp_o.x_issue_resp.writeback = accept && dec_we;
      cvxif_resp_o.x_result_valid         = !fifo_empty;
      if (!fifo_empty) begin
         cvxif_resp_o.x_result.id      = fifo_head.id;
         cvxif_resp_o.x_result.data    = fifo_head.data;
         cvxif_resp_o.x_result.we      = fifo_head.we;
         cvxif_resp_o.x_result.exc     = fifo_head.exc;
         cvxif_resp_o.x_result.exccode = fifo_head.exccode;
      end
   end

   assign busy_o = fsm_busy || !fifo_empty;

   logic unused_inputs;
   assign unused_inputs = ^{ireq.mode, cvxif_req_i.x_commit_valid, cvxif_req_i.x_commit,
                            dec_mul, fifo_count};

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Randomised bench for cvxif_copro_responder against a queue-based reference
// model; follows COPRO_MUL_EN the same way as the design.
module tb_cvxif_copro_responder;
   import cvxif_pkg::*;

   localparam int unsigned DEPTH       = 4;
   localparam int unsigned MUL_LATENCY = 3;
`ifdef COPRO_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic        we;
      logic        exc;
      logic [5:0]  exccode;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   cvxif_req_t  req;
   cvxif_resp_t resp;
   logic        busy_o;

   cvxif_copro_responder #(
      .DEPTH       (DEPTH),
      .MUL_LATENCY (MUL_LATENCY)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .cvxif_req_i  (req),
      .cvxif_resp_o (resp),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   exp_t      q[$];
   bit        pend;
   exp_t      pend_e;
   int        pend_left;
   bit        held;
   x_result_t held_res;
   int        n_cmp = 0;
   int        n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit mdl_decode(input x_issue_req_t r, output exp_t e, output bit is_mul);
      logic [63:0] p;
      e       = '0;
      e.id    = r.id;
      is_mul  = 1'b0;
      if (r.instr[6:0] != 7'h7B || r.instr[31:25] != 7'd0) return 1'b0;
      case (r.instr[14:12])
         3'd0: begin
            if (r.rs_valid != 2'b11) return 1'b0;
            e.data = r.rs[0] + r.rs[1];
            e.we   = 1'b1;
            return 1'b1;
         end
         3'd1: begin
            if (!MUL_EN || r.rs_valid != 2'b11) return 1'b0;
            p      = 64'(r.rs[0]) * 64'(r.rs[1]);
            e.data = p[31:0];
            e.we   = 1'b1;
            is_mul = 1'b1;
            return 1'b1;
         end
         3'd2: return 1'b1;
         3'd3: begin
            e.exc     = 1'b1;
            e.exccode = r.rs[1][5:0];
            return 1'b1;
         end
         default: return 1'b0;
      endcase
   endfunction

   // One clock: check outputs against the model, advance the model, step the clock.
   task automatic cyc();
      bit        exp_acc, is_mul, pend0, exp_ready;
      exp_t      e, h;
      x_result_t r;
      int        sz;
      #1;
      sz        = q.size();
      pend0     = pend;
      exp_ready = !pend0 && (sz < int'(DEPTH));
      chk("issue_ready", resp.x_issue_ready, exp_ready);
      chk("result_valid", resp.x_result_valid, sz != 0);
      chk("busy", busy_o, pend0 || sz != 0);
      chk("resp_flags", {resp.x_issue_resp.dualwrite, resp.x_issue_resp.dualread,
                         resp.x_issue_resp.loadstore, resp.x_issue_resp.exc}, 0);
      r = resp.x_result;
      if (held) chk("result_stable", r, held_res);
      held = 1'b0;
      if (sz != 0) begin
         h = q[0];
         chk("result_head", {r.id, r.data, r.we, r.exc, r.exccode}, h);
         if (req.x_result_ready) void'(q.pop_front());
         else begin
            held     = 1'b1;
            held_res = r;
         end
      end
      if (pend0) begin
         if (req.x_commit_valid && req.x_commit.x_commit_kill && req.x_commit.id == pend_e.id)
            pend = 1'b0;
         else if (pend_left > 1)
            pend_left--;
         else if (sz < int'(DEPTH)) begin
            q.push_back(pend_e);
            pend = 1'b0;
         end
      end
      if (req.x_issue_valid) begin
         exp_acc = mdl_decode(req.x_issue_req, e, is_mul);
         chk("accept", resp.x_issue_resp.accept, exp_acc);
         chk("writeback", resp.x_issue_resp.writeback, exp_acc && e.we);
         if (exp_ready && exp_acc) begin
            if (is_mul) begin
               pend      = 1'b1;
               pend_e    = e;
               pend_left = MUL_LATENCY;
            end else begin
               q.push_back(e);
            end
         end
      end
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic set_issue(input logic [3:0] id, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b);
      req.x_issue_valid              = 1'b1;
      req.x_issue_req.instr          = {7'd0, 5'd2, 5'd1, f3, 5'd3, 7'h7B};
      req.x_issue_req.id             = id;
      req.x_issue_req.rs[0]          = a;
      req.x_issue_req.rs[1]          = b;
      req.x_issue_req.rs_valid       = 2'b11;
   endtask

   task automatic clear_issue();
      req.x_issue_valid = 1'b0;
      req.x_issue_req   = '0;
   endtask

   task automatic do_reset();
      req    = '0;
      rst_ni = 1'b0;
      q.delete();
      pend = 1'b0;
      held = 1'b0;
      #1;
      chk("rst_issue_ready", resp.x_issue_ready, 1);
      chk("rst_result_valid", resp.x_result_valid, 0);
      chk("rst_result", resp.x_result, 0);
      chk("rst_accept", resp.x_issue_resp.accept, 0);
      chk("rst_busy", busy_o, 0);
      @(posedge clk_i);
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   ids[$];
      int   nlow;
      bit   got;
      bit   seen9;
      logic [2:0] f3;
      logic [6:0] opc, f7;

      do_reset();

      // ADD id 5: 3 + 4
      req.x_result_ready = 1'b1;
      set_issue(4'd5, 3'd0, 32'd3, 32'd4);
      #1 chk("add_accept", resp.x_issue_resp.accept, 1);
      cyc();
      clear_issue();
      #1;
      chk("add_valid", resp.x_result_valid, 1);
      chk("add_data", resp.x_result.data, 7);
      chk("add_id", resp.x_result.id, 5);
      chk("add_we_exc", {resp.x_result.we, resp.x_result.exc}, 2'b10);
      cyc();

      // Unknown funct3 is consumed and produces nothing
      set_issue(4'd3, 3'd7, 32'd1, 32'd1);
      #1;
      chk("bad_accept", resp.x_issue_resp.accept, 0);
      chk("bad_ready", resp.x_issue_ready, 1);
      cyc();
      clear_issue();
      for (int i = 0; i < 5; i++) cyc();

      // Multiply id 2: 6 * 7
      set_issue(4'd2, 3'd1, 32'd6, 32'd7);
`ifdef COPRO_MUL_EN
      cyc();
      clear_issue();
      nlow = 0;
      got  = 1'b0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (!resp.x_issue_ready) nlow++;
         if (resp.x_result_valid && !got) begin
            got = 1'b1;
            chk("mul_data", resp.x_result.data, 42);
            chk("mul_id", resp.x_result.id, 2);
         end
         cyc();
      end
      chk("mul_done", got, 1);
      chk("mul_stall_cycles", nlow, MUL_LATENCY);
`else
      #1 chk("mul_rejected", resp.x_issue_resp.accept, 0);
      cyc();
      clear_issue();
      for (int i = 0; i < 4; i++) cyc();
`endif

      // Backpressure: fill the buffer, fifth issue stalls, drain in order
      req.x_result_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_issue(4'(i), 3'd0, $urandom, $urandom);
         cyc();
      end
      set_issue(4'd4, 3'd0, 32'd1, 32'd1);
      #1 chk("full_ready", resp.x_issue_ready, 0);
      for (int i = 0; i < 3; i++) cyc();
      clear_issue();
      req.x_result_ready = 1'b1;
      ids.delete();
      for (int i = 0; i < 8; i++) begin
         #1;
         if (resp.x_result_valid) ids.push_back(int'(resp.x_result.id));
         cyc();
      end
      chk("order_count", ids.size(), 4);
      for (int i = 0; i < 4 && i < ids.size(); i++) chk("order_id", ids[i], i);

`ifdef COPRO_MUL_EN
      // Kill an in-flight multiply
      set_issue(4'd9, 3'd1, 32'd5, 32'd5);
      cyc();
      clear_issue();
      req.x_commit_valid              = 1'b1;
      req.x_commit.x_commit_kill      = 1'b1;
      req.x_commit.id                 = 4'd9;
      cyc();
      req.x_commit = '0;
      req.x_commit_valid = 1'b0;
      seen9 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (resp.x_result_valid && resp.x_result.id == 4'd9) seen9 = 1'b1;
         cyc();
      end
      chk("kill_no_result", seen9, 0);
      chk("kill_idle", busy_o, 0);
      set_issue(4'd4, 3'd0, 32'd1, 32'd1);
      cyc();
      clear_issue();
      #1 chk("post_kill_add", resp.x_result.data, 2);
      cyc();
`endif

      // Exception reporting
      set_issue(4'd1, 3'd3, 32'd0, 32'd2);
      cyc();
      clear_issue();
      #1;
      chk("exc_flag", resp.x_result.exc, 1);
      chk("exc_code", resp.x_result.exccode, 2);
      chk("exc_we", resp.x_result.we, 0);
      cyc();

      // Reset with buffered results discards them
      req.x_result_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_issue(4'(i + 10), 3'd0, $urandom, $urandom);
         cyc();
      end
      do_reset();
      #1;
      chk("midrst_valid", resp.x_result_valid, 0);
      chk("midrst_busy", busy_o, 0);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         req.x_issue_valid = ($urandom_range(0, 9) < 6);
         f3  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
         opc = ($urandom_range(0, 19) == 0) ? 7'h33 : 7'h7B;
         f7  = ($urandom_range(0, 19) == 0) ? 7'h01 : 7'h00;
         req.x_issue_req.instr    = {f7, 10'($urandom), f3, 5'($urandom), opc};
         req.x_issue_req.id       = 4'($urandom);
         req.x_issue_req.rs[0]    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         req.x_issue_req.rs[1]    = $urandom;
         req.x_issue_req.rs_valid = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b11;
         req.x_result_ready       = ($urandom_range(0, 9) < 7);
         req.x_commit_valid       = ($urandom_range(0, 9) < 2);
         req.x_commit.x_commit_kill = 1'b1;
         req.x_commit.id          = (pend && $urandom_range(0, 1) == 1) ? pend_e.id : 4'($urandom);
         cyc();
      end

      clear_issue();
      req.x_commit_valid = 1'b0;
      req.x_result_ready = 1'b1;
      for (int i = 0; i < 50 && (q.size() != 0 || pend); i++) cyc();
      chk("drain_empty", q.size() + int'(pend), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
